// File: rtl/im_loadable.sv
// Loadable instruction memory for the pmips core: registered one-cycle read port,
// post-reset fill with FILL_WORD, and a byte-wide loader that streams in a new program.
module im_loadable #(
  parameter int              DW        = 16,
  parameter int              AW        = 3,
  parameter logic [DW-1:0]   FILL_WORD = 16'h0002
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [15:0]   iaddr,
  output logic [DW-1:0] idata,
  output logic          ivalid,
  output logic          busy,
  input  logic          ld_start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [7:0]    ld_byte,
  input  logic          ld_last,
  output logic          ld_done,
  output logic          ld_overflow,
  output logic [AW:0]   ld_count
);

  localparam int            BPW     = DW / 8;
  localparam int            BCW     = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int            DEPTH   = 1 << AW;
  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD} state_t;

  state_t           state_q;
  logic [AW-1:0]    clr_cnt_q;
  logic [BCW-1:0]   byte_cnt_q;
  logic [DW-1:0]    shift_q;
  logic [AW:0]      ld_count_q;
  logic [DW-1:0]    idata_q;
  logic             ivalid_q;
  logic             ld_done_q;
  logic             ld_overflow_q;
  logic [DW-1:0]    mem_q [DEPTH];

  logic             accept;
  logic             full;
  logic             word_end;
  logic [DW+7:0]    cat;
  logic [DW-1:0]    shift_n;
  logic [DW-1:0]    pad_word;
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [DW-1:0]    mem_wd;
  logic             unused_bits;

  // Loader handshake: a byte transfers on every rising edge where ld_valid && ld_ready;
  // ld_ready is high for the whole of LOAD and depends only on the state register.
  assign ld_ready = (state_q == S_LOAD);
  assign busy     = (state_q != S_IDLE);
  assign accept   = ld_ready && ld_valid;
  assign full     = (ld_count_q == DEPTH_C);
  assign word_end = (byte_cnt_q == BCW'(BPW - 1));
  assign cat      = {shift_q, ld_byte};
  assign shift_n  = cat[DW-1:0];
  // A short final word keeps its bytes MSB-aligned with zeros below.
  assign pad_word = shift_n << ((BPW - 1 - int'(byte_cnt_q)) * 8);
  assign unused_bits = ^{iaddr[15:AW+1], iaddr[0], cat[DW+7:DW]};

  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (!reset) begin
      case (state_q)
        S_CLEAR: begin
          mem_we = 1'b1;
          mem_wa = clr_cnt_q;
          mem_wd = FILL_WORD;
        end
        S_LOAD: begin
          if (accept && !full && (word_end || ld_last)) begin
            mem_we = 1'b1;
            mem_wa = ld_count_q[AW-1:0];
            mem_wd = word_end ? shift_n : pad_word;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_CLEAR;
      clr_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      shift_q       <= '0;
      ld_count_q    <= '0;
      idata_q       <= '0;
      ivalid_q      <= 1'b0;
      ld_done_q     <= 1'b0;
      ld_overflow_q <= 1'b0;
    end else begin
      ld_done_q <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          idata_q   <= '0;
          ivalid_q  <= 1'b0;
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == AW'(DEPTH - 1)) state_q <= S_IDLE;
        end
        S_IDLE: begin
          idata_q  <= mem_q[iaddr[AW:1]];
          ivalid_q <= 1'b1;
          if (ld_start) begin
            state_q       <= S_LOAD;
            byte_cnt_q    <= '0;
            shift_q       <= '0;
            ld_count_q    <= '0;
            ld_overflow_q <= 1'b0;
          end
        end
        S_LOAD: begin
          idata_q  <= '0;
          ivalid_q <= 1'b0;
          if (accept) begin
            // Once DEPTH words are in, extra bytes are dropped rather than wrapping.
            if (full) begin
              ld_overflow_q <= 1'b1;
            end else if (word_end || ld_last) begin
              ld_count_q <= ld_count_q + 1'b1;
              byte_cnt_q <= '0;
              shift_q    <= '0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
              shift_q    <= shift_n;
            end
            if (ld_last) begin
              state_q   <= S_IDLE;
              ld_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign idata       = idata_q;
  assign ivalid      = ivalid_q;
  assign ld_done     = ld_done_q;
  assign ld_overflow = ld_overflow_q;
  assign ld_count    = ld_count_q;

endmodule

// File: tb/tb_im_loadable.sv
// Bench for im_loadable: directed loads and reads, with a scoreboard that checks
// every requested read and every ld_done pulse against hand-computed values.
module tb_im_loadable;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   iaddr = '0;
  logic [DW-1:0] idata;
  logic          ivalid;
  logic          busy;
  logic          ld_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [7:0]    ld_byte = '0;
  logic          ld_last = 1'b0;
  logic          ld_done;
  logic          ld_overflow;
  logic [AW:0]   ld_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];
  logic [AW:0]   done_q[$];
  logic [7:0]    bq[$];
  logic          rd_req = 1'b0;
  logic          rd_pend = 1'b0;

  im_loadable #(.DW(DW), .AW(AW), .FILL_WORD(16'h0002)) dut (
    .clock(clock), .reset(reset), .iaddr(iaddr), .idata(idata), .ivalid(ivalid),
    .busy(busy), .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_byte(ld_byte), .ld_last(ld_last), .ld_done(ld_done),
    .ld_overflow(ld_overflow), .ld_count(ld_count)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clock) rd_pend <= rd_req;

  always @(negedge clock) begin : monitor
    logic [DW-1:0] e;
    logic [AW:0]   c;
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL read_unexpected: got data %0h, expected no pending read", idata);
      end else begin
        e = exp_q.pop_front();
        check("read_valid", 32'(ivalid), 32'd1);
        check("read_data", 32'(idata), 32'(e));
      end
    end
    if (ld_done) begin
      if (done_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL done_unexpected: got ld_done=1, expected 0");
      end else begin
        c = done_q.pop_front();
        check("done_count", 32'(ld_count), 32'(c));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [DW-1:0] e);
    iaddr  = a;
    rd_req = 1'b1;
    exp_q.push_back(e);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic wait_clear();
    int n;
    n = 0;
    repeat (20) begin
      @(negedge clock);
      if (!busy) break;
      n++;
    end
    check("clear_cycles", 32'(n), 32'd8);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    wait_clear();
  endtask

  task automatic load(input bit gaps, input logic [AW:0] exp_cnt);
    done_q.push_back(exp_cnt);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("load_ready", 32'(ld_ready), 32'd1);
    for (int i = 0; i < bq.size(); i++) begin
      ld_valid = 1'b1;
      ld_byte  = bq[i];
      ld_last  = (i == bq.size() - 1);
      tick();
      if (gaps) begin
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        tick();
      end
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    tick();
    tick();
    check("ld_count", 32'(ld_count), 32'(exp_cnt));
    check("busy_after_load", 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] ovf_words [8];
    ovf_words = '{16'h0011, 16'h2233, 16'h4455, 16'h6677,
                  16'h8899, 16'hAABB, 16'hCCDD, 16'hEEFF};

    tick();
    tick();
    check("rst_idata", 32'(idata), 32'd0);
    check("rst_ivalid", 32'(ivalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_ld_done", 32'(ld_done), 32'd0);
    check("rst_ld_overflow", 32'(ld_overflow), 32'd0);
    check("rst_ld_count", 32'(ld_count), 32'd0);
    reset = 1'b0;
    wait_clear();

    for (int i = 0; i < 8; i++) rd(16'(2 * i), 16'h0002);
    tick();

    // Full program of four words.
    bq = '{8'h60, 8'h03, 8'h00, 8'h43, 8'h04, 8'h43, 8'h41, 8'h7C};
    load(1'b0, 4'd4);
    rd(16'd0, 16'h6003);
    rd(16'd2, 16'h0043);
    rd(16'd4, 16'h0443);
    rd(16'd6, 16'h417C);
    rd(16'd8, 16'h0002);
    rd(16'd14, 16'h0002);
    tick();

    // Odd byte count: last word padded, address alias through iaddr[3:1].
    bq = '{8'hAA, 8'hBB, 8'hCC};
    load(1'b0, 4'd2);
    rd(16'd0, 16'hAABB);
    rd(16'd2, 16'hCC00);
    rd(16'd17, 16'hAABB);
    rd(16'd4, 16'h0443);
    tick();
    check("no_overflow", 32'(ld_overflow), 32'd0);

    // 18 bytes with gaps: 8 words fill memory, 2 bytes overflow.
    bq = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
           8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h12, 8'h34};
    load(1'b1, 4'd8);
    check("overflow_set", 32'(ld_overflow), 32'd1);
    for (int i = 0; i < 8; i++) rd(16'(2 * i), ovf_words[i]);
    tick();

    // New load clears overflow; ld_start inside LOAD is ignored.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("overflow_cleared", 32'(ld_overflow), 32'd0);
    check("load_busy", 32'(busy), 32'd1);
    iaddr    = 16'd0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("load_ivalid", 32'(ivalid), 32'd0);
    check("load_idata", 32'(idata), 32'd0);
    check("stay_load_ready", 32'(ld_ready), 32'd1);
    check("stay_load_busy", 32'(busy), 32'd1);

    // Three bytes then reset mid-load.
    bq = '{8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_byte  = bq[i];
      tick();
    end
    ld_valid = 1'b0;
    check("partial_count", 32'(ld_count), 32'd1);
    do_reset();
    check("post_rst_count", 32'(ld_count), 32'd0);
    check("post_rst_overflow", 32'(ld_overflow), 32'd0);
    for (int i = 0; i < 8; i++) rd(16'(2 * i), 16'h0002);
    tick();
    tick();

    check("reads_drained", 32'(exp_q.size()), 32'd0);
    check("dones_seen", 32'(done_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/im_loadable.md
Name: im_loadable

Overview:
- Parametrised successor to the fixed-program instruction ROM for the pmips core.
- Holds a DEPTH-word, DW-bit synchronous instruction memory.
- Read port: registered, one-cycle latency, driven by the CPU fetch address.
- After reset the memory is filled with FILL_WORD. A host can then stream a new program byte-wise through a valid/ready loader port, with no resynthesis needed to change programs.

Parameters:
- DW, 16, instruction width in bits; must be a multiple of 8. BPW = DW/8 bytes per word.
- AW, 3, word-address bits; DEPTH = 2^AW words.
- FILL_WORD, 16'h0002, value written to every location during post-reset clear.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- iaddr  in  16  CPU byte address. Word index = iaddr[AW:1]. iaddr[0] and bits above AW are ignored, so addresses wrap.
- idata  out  DW  registered instruction word.
- ivalid  out  1  idata holds a valid read of the address presented last cycle.
- busy  out  1  high in CLEAR or LOAD; the CPU must stall.
- ld_start  in  1  begin program load; honoured only in IDLE.
- ld_valid  in  1  ld_byte is valid.
- ld_ready  out  1  loader accepts a byte this cycle.
- ld_byte  in  8  program byte; most-significant byte of each word first.
- ld_last  in  1  qualifies the final byte of the program.
- ld_done  out  1  one-cycle pulse when a load completes.
- ld_overflow  out  1  sticky: bytes arrived after DEPTH words were written. Cleared on ld_start or reset.
- ld_count  out  AW+1  number of words written by the current or last load.

Behaviour:
- Reset (synchronous):
  - FSM enters CLEAR. Clear counter = 0.
  - Output values: idata=0, ivalid=0, busy=1, ld_ready=0, ld_done=0, ld_overflow=0, ld_count=0.
  - Memory contents are not reset directly; they are rewritten by CLEAR.
- States: CLEAR, IDLE, LOAD.
- CLEAR:
  - Writes FILL_WORD to address = counter each cycle, then increments the counter.
  - After writing DEPTH-1, goes to IDLE. Total DEPTH cycles.
  - busy=1, ld_ready=0. ld_start is ignored.
- IDLE:
  - Each cycle, idata <= mem[iaddr[AW:1]] and ivalid <= 1. Latency is exactly one clock.
  - busy=0.
  - ld_start=1 -> LOAD next cycle. On that transition: waddr=0, byte counter=0, shift register=0, ld_count=0, ld_overflow=0.
- LOAD:
  - busy=1, ld_ready=1. idata <= 0, ivalid <= 0.
  - A byte is accepted on a cycle where ld_valid=1 and ld_ready=1. The shift register takes {shift[DW-9:0], ld_byte}.
  - When the byte counter reaches BPW-1 on an accepted byte:
    - write the assembled word to mem[waddr];
    - waddr++ and ld_count++;
    - clear the byte counter.
  - Gaps in ld_valid are allowed. The state is held and nothing is written.
  - ld_last on an accepted byte when the word is partial: the word is left-aligned (MSB-first) and zero-padded in its low bytes, then written. ld_count increments.
  - ld_last on an accepted byte that completes a word: normal write.
  - Either ld_last case -> IDLE next cycle, with ld_done=1 for exactly that one cycle.
  - Once ld_count=DEPTH, any further accepted byte is discarded with no write and no wrap, and ld_overflow is set. ld_last is still honoured.
  - ld_start in LOAD is ignored.
- Read-while-write: none. The read port is idle during CLEAR and LOAD.
- Reset mid-LOAD or mid-CLEAR: abort immediately and restart CLEAR. Partially loaded words are overwritten with FILL_WORD.
- ld_done and ld_overflow are registered outputs.
- ld_count saturates at DEPTH.

Test Plan:
- Reset, then hold reset low for DEPTH=8 cycles:
  - busy must be high for exactly 8 cycles.
  - Then iaddr=0,2,...,14 -> idata=16'h0002 one cycle later, ivalid=1.
- Load 8 bytes 60 03 00 43 04 43 41 7C with ld_last on the final byte:
  - ld_done pulses once; ld_count=4.
  - Reads give iaddr=0 -> 16'h6003, iaddr=2 -> 16'h0043, iaddr=4 -> 16'h0443, iaddr=6 -> 16'h417C.
  - iaddr=8 -> 16'h0002.
- Load 3 bytes AA BB CC with ld_last on CC:
  - ld_count=2; word0=16'hAABB, word1=16'hCC00.
  - iaddr=17 aliases word0: idata=16'hAABB.
- Load 18 bytes with ld_valid toggled every other cycle:
  - ld_count=8 and all 8 words are correct.
  - ld_overflow=1.
  - A subsequent ld_start clears ld_overflow.
- Assert reset after 3 bytes of a load:
  - busy stays high for the 8 clear cycles.
  - All words then read 16'h0002; ld_count=0.
- During LOAD, drive iaddr=0 and pulse ld_start: ivalid=0, idata=0, and the FSM stays in LOAD.
